// File: rtl/mux_sweep_checker.sv
// Exhaustive sweep tester for a 2-to-1 mux: drives all 8 {s,y,x} vectors,
// samples m after a settle delay and reports error count and first failing vector.
module mux_sweep_checker #(
   parameter int unsigned SETTLE_CYCLES = 2
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       start,
   input  logic       m,
   output logic       x,
   output logic       y,
   output logic       s,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [3:0] err_count,
   output logic [2:0] fail_vec
);

   typedef enum logic [2:0] {
      StIdle,
      StApply,
      StWait,
      StSample,
      StDone
   } state_e;

   localparam logic [3:0] CntLoad = 4'(SETTLE_CYCLES - 1);

   state_e     state_q, state_d;
   logic [2:0] v_q, v_d;
   logic [3:0] cnt_q, cnt_d;
   logic [2:0] xys_q, xys_d;
   logic       pass_q, pass_d;
   logic [3:0] err_q, err_d;
   logic [2:0] fail_q, fail_d;
   logic       expected;
   logic       mismatch;

   assign expected = v_q[2] ? v_q[1] : v_q[0];
   assign mismatch = (m != expected);

   // State register
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:   if (start) state_d = StApply;
         StApply:  state_d = StWait;
         StWait:   if (cnt_q == 4'd0) state_d = StSample;
         StSample: state_d = (v_q == 3'd7) ? StDone : StApply;
         StDone:   state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   // Output decode straight from the state register
   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      unique case (state_q)
         StApply, StWait, StSample: busy = 1'b1;
         StDone:                    done = 1'b1;
         default:                   ;
      endcase
   end

   // Datapath next-state
   always_comb begin
      v_d    = v_q;
      cnt_d  = cnt_q;
      xys_d  = xys_q;
      pass_d = pass_q;
      err_d  = err_q;
      fail_d = fail_q;
      unique case (state_q)
         StIdle: begin
            xys_d = 3'd0;
            if (start) begin
               v_d    = 3'd0;
               xys_d  = 3'd0;
               err_d  = 4'd0;
               fail_d = 3'd0;
               pass_d = 1'b0;
            end
         end
         StApply: begin
            cnt_d = CntLoad;
         end
         StWait: begin
            if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
         end
         StSample: begin
            if (mismatch) begin
               if (err_q < 4'd8) err_d = err_q + 4'd1;
               if (err_q == 4'd0) fail_d = v_q;
            end
            if (v_q == 3'd7) begin
               // pass must be valid in the DONE cycle, so it sees this sample's update
               pass_d = (err_d == 4'd0);
               xys_d  = 3'd0;
            end else begin
               v_d   = v_q + 3'd1;
               xys_d = v_q + 3'd1;
            end
         end
         StDone: begin
            xys_d = 3'd0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         v_q    <= 3'd0;
         cnt_q  <= 4'd0;
         xys_q  <= 3'd0;
         pass_q <= 1'b0;
         err_q  <= 4'd0;
         fail_q <= 3'd0;
      end else begin
         v_q    <= v_d;
         cnt_q  <= cnt_d;
         xys_q  <= xys_d;
         pass_q <= pass_d;
         err_q  <= err_d;
         fail_q <= fail_d;
      end
   end

   assign x         = xys_q[0];
   assign y         = xys_q[1];
   assign s         = xys_q[2];
   assign pass      = pass_q;
   assign err_count = err_q;
   assign fail_vec  = fail_q;

endmodule

// File: tb/tb_mux_sweep_checker.sv
// Directed bench for mux_sweep_checker: a behavioural mux with selectable faults
// sits between stimulus and m; a second instance runs with SETTLE_CYCLES=1.
module tb_mux_sweep_checker;

   logic       clock;
   logic       reset;
   logic       start;
   logic       m;
   logic       x, y, s;
   logic       busy, done, pass;
   logic [3:0] err_count;
   logic [2:0] fail_vec;

   logic       start1;
   logic       m1;
   logic       x1, y1, s1;
   logic       busy1, done1, pass1;
   logic [3:0] err_count1;
   logic [2:0] fail_vec1;

   int mode;  // 0 ideal, 1 stuck-at-0, 2 inverted, 3 m=x (select fault)
   int total;
   int bad;

   mux_sweep_checker #(.SETTLE_CYCLES(2)) dut (
      .clock(clock), .reset(reset), .start(start), .m(m),
      .x(x), .y(y), .s(s), .busy(busy), .done(done), .pass(pass),
      .err_count(err_count), .fail_vec(fail_vec)
   );

   mux_sweep_checker #(.SETTLE_CYCLES(1)) dut1 (
      .clock(clock), .reset(reset), .start(start1), .m(m1),
      .x(x1), .y(y1), .s(s1), .busy(busy1), .done(done1), .pass(pass1),
      .err_count(err_count1), .fail_vec(fail_vec1)
   );

   always_comb begin
      m = s ? y : x;
      case (mode)
         1: m = 1'b0;
         2: m = ~(s ? y : x);
         3: m = x;
         default: ;
      endcase
   end

   assign m1 = s1 ? y1 : x1;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Pulses start, returns cycle (after the start edge) at which done is seen, 0 on timeout.
   task automatic run_sweep(input int pulse_at, output int cyc, output int busy_n,
                            output int order_bad);
      int n;
      cyc = 0; busy_n = 0; order_bad = 0; n = 0;
      start = 1'b1;
      while (n < 200) begin
         @(negedge clock);
         n++;
         start = (n == pulse_at);
         if (busy) busy_n++;
         if (n <= 32 && ((n - 1) % 4) == 0 && {s, y, x} !== 3'((n - 1) / 4)) order_bad++;
         if (done) begin
            cyc = n;
            break;
         end
      end
      start = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b1; start = 1'b0; start1 = 1'b0; mode = 0;
      repeat (3) @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      total++;
      if ({busy, done, pass, err_count, fail_vec, s, y, x} !== 13'd0) begin
         bad++;
         $display("FAIL reset_state: got %b want all zero",
                  {busy, done, pass, err_count, fail_vec, s, y, x});
      end
   endtask

   task automatic test_ideal;
      int cyc, bn, ob;
      mode = 0;
      run_sweep(0, cyc, bn, ob);
      total++;
      if (cyc !== 33) begin bad++; $display("FAIL ideal_latency: got %0d want 33", cyc); end
      total++;
      if (bn !== 32) begin bad++; $display("FAIL ideal_busy: got %0d want 32", bn); end
      total++;
      if (ob !== 0) begin bad++; $display("FAIL ideal_order: got %0d bad vectors want 0", ob); end
      total++;
      if ({pass, err_count, fail_vec, busy} !== {1'b1, 4'd0, 3'd0, 1'b0}) begin
         bad++;
         $display("FAIL ideal_result: got pass=%b err=%0d fail=%0d busy=%b want 1 0 0 0",
                  pass, err_count, fail_vec, busy);
      end
      @(negedge clock);
      total++;
      if ({done, pass} !== 2'b01) begin
         bad++; $display("FAIL ideal_hold: got done=%b pass=%b want 0 1", done, pass);
      end
   endtask

   task automatic test_faults;
      int cyc, bn, ob;
      logic [3:0] exp_err [3];
      logic [2:0] exp_fv  [3];
      exp_err = '{4'd4, 4'd8, 4'd2};
      exp_fv  = '{3'd1, 3'd0, 3'd5};
      for (int i = 0; i < 3; i++) begin
         mode = i + 1;
         run_sweep(0, cyc, bn, ob);
         total++;
         if ({cyc, pass, err_count, fail_vec} !== {33, 1'b0, exp_err[i], exp_fv[i]}) begin
            bad++;
            $display("FAIL fault_mode%0d: got cyc=%0d pass=%b err=%0d fail=%0d want 33 0 %0d %0d",
                     mode, cyc, pass, err_count, fail_vec, exp_err[i], exp_fv[i]);
         end
         @(negedge clock);
      end
      mode = 0;
      run_sweep(0, cyc, bn, ob);
      total++;
      if ({pass, err_count, fail_vec} !== {1'b1, 4'd0, 3'd0}) begin
         bad++;
         $display("FAIL clean_after_fault: got pass=%b err=%0d fail=%0d want 1 0 0",
                  pass, err_count, fail_vec);
      end
      @(negedge clock);
   endtask

   task automatic test_mid_reset;
      int cyc, bn, ob;
      int saw_done;
      mode = 3;
      saw_done = 0;
      start = 1'b1;
      // cycle 14 after the start edge is the first WAIT cycle of vector 3
      for (int n = 1; n <= 14; n++) begin
         @(negedge clock);
         start = 1'b0;
         if (done) saw_done++;
      end
      total++;
      if ({s, y, x, busy} !== 4'b0111) begin
         bad++; $display("FAIL pre_reset_vec: got %b want 0111", {s, y, x, busy});
      end
      reset = 1'b1;
      start = 1'b1;  // reset must win over start
      @(negedge clock);
      reset = 1'b0;
      start = 1'b0;
      if (done) saw_done++;
      total++;
      if ({busy, done, pass, err_count, fail_vec, s, y, x} !== 13'd0 || saw_done != 0) begin
         bad++;
         $display("FAIL mid_reset: got %b done_seen=%0d want all zero",
                  {busy, done, pass, err_count, fail_vec, s, y, x}, saw_done);
      end
      @(negedge clock);
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL reset_idle: got busy=%b want 0", busy); end
      mode = 0;
      run_sweep(0, cyc, bn, ob);
      total++;
      if ({cyc, pass} !== {33, 1'b1}) begin
         bad++; $display("FAIL post_reset_sweep: got cyc=%0d pass=%b want 33 1", cyc, pass);
      end
      @(negedge clock);
   endtask

   task automatic test_start_while_busy;
      int cyc, bn, ob;
      mode = 0;
      run_sweep(10, cyc, bn, ob);
      total++;
      if ({cyc, bn, ob} !== {33, 32, 0}) begin
         bad++; $display("FAIL start_busy: got cyc=%0d busy=%0d ob=%0d want 33 32 0", cyc, bn, ob);
      end
      @(negedge clock);
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL start_busy_idle: got busy=%b want 0", busy); end
      @(negedge clock);
   endtask

   task automatic test_back_to_back;
      int n, cyc, n_idle_busy, n_next_busy;
      logic [2:0] next_vec;
      mode = 0;
      start = 1'b1;
      n = 0; cyc = 0; n_idle_busy = 1; n_next_busy = 0; next_vec = 3'd7;
      while (n < 100) begin
         @(negedge clock);
         n++;
         if (done && cyc == 0) cyc = n;
         if (cyc != 0 && n == cyc + 1) n_idle_busy = busy;
         if (cyc != 0 && n == cyc + 2) begin
            n_next_busy = busy;
            next_vec = {s, y, x};
            break;
         end
      end
      start = 1'b0;
      total++;
      if ({cyc, n_idle_busy[0], n_next_busy[0], next_vec} !== {33, 1'b0, 1'b1, 3'd0}) begin
         bad++;
         $display("FAIL back_to_back: got cyc=%0d idle_busy=%0d next_busy=%0d vec=%0d want 33 0 1 0",
                  cyc, n_idle_busy, n_next_busy, next_vec);
      end
      n = 0;
      while (!done && n < 100) begin
         @(negedge clock);
         n++;
      end
      @(negedge clock);
   endtask

   task automatic test_settle1;
      int n, cyc, bn;
      start1 = 1'b1;
      n = 0; cyc = 0; bn = 0;
      while (n < 100) begin
         @(negedge clock);
         n++;
         start1 = 1'b0;
         if (busy1) bn++;
         if (done1) begin
            cyc = n;
            break;
         end
      end
      total++;
      if ({cyc, bn, pass1, err_count1} !== {25, 24, 1'b1, 4'd0}) begin
         bad++;
         $display("FAIL settle1: got cyc=%0d busy=%0d pass=%b err=%0d want 25 24 1 0",
                  cyc, bn, pass1, err_count1);
      end
   endtask

   initial begin
      total = 0;
      bad = 0;
      start = 1'b0;
      start1 = 1'b0;
      reset = 1'b1;
      mode = 0;
      test_reset();
      test_ideal();
      test_faults();
      test_mid_reset();
      test_start_while_busy();
      test_back_to_back();
      test_settle1();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
